// File: rtl/tv80_bus_pkg.sv
// Shared types and constants for the TV80-style bus cycle sequencer:
// state encoding, the active-low strobe bundle and default wait-state counts.
package tv80_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_TW   = 3'd3,
      ST_T3   = 3'd4,
      ST_HOLD = 3'd5
   } bus_state_e;

   typedef struct packed {
      logic m1_n;
      logic mreq_n;
      logic iorq_n;
      logic rd_n;
      logic wr_n;
   } bus_strobe_t;

   localparam bus_strobe_t STROBE_IDLE = '{m1_n: 1'b1, mreq_n: 1'b1, iorq_n: 1'b1,
                                          rd_n: 1'b1, wr_n: 1'b1};

   localparam int DEF_MEM_WAIT = 0;
   localparam int DEF_IO_WAIT  = 1;
   localparam int WAIT_CW      = 3;

endpackage

// File: rtl/tv80_wait_cnt.sv
// Forced wait-state counter: loads on entry to T2, counts down saturating at
// zero, and flags zero so the sequencer knows the forced waits are spent.
module tv80_wait_cnt
   import tv80_bus_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic [WAIT_CW-1:0] i_load_val,
   input  logic               i_dec,
   output logic               o_zero
);

   logic [WAIT_CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tv80_bus_seq.sv
// Z80-style bus cycle sequencer: turns core requests into T1/T2/TW/T3 bus
// cycles with registered strobes, forced/external wait states and bus hold.
module tv80_bus_seq
   import tv80_bus_pkg::*;
#(
   parameter int AW       = 16,
   parameter int DW       = 8,
   parameter int MEM_WAIT = DEF_MEM_WAIT,
   parameter int IO_WAIT  = DEF_IO_WAIT,
   parameter int T2_WRITE = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic          req_io,
   input  logic          req_m1,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   input  logic          wait_n,
   input  logic          busrq_n,
   output logic          busak_n,
   output logic          bus_oe,
   input  logic [DW-1:0] di,
   output logic [AW-1:0] A,
   output logic [DW-1:0] dout,
   output logic          m1_n,
   output logic          mreq_n,
   output logic          iorq_n,
   output logic          rd_n,
   output logic          wr_n
);

   localparam logic W_EARLY_WR = (T2_WRITE != 0);

   bus_state_e         r_state, w_next;
   logic [AW-1:0]      r_addr;
   logic [DW-1:0]      r_wdata, r_rdata;
   logic               r_write, r_io, r_m1;
   logic               r_busak_n, r_bus_oe;
   bus_strobe_t        r_stb, w_stb;
   logic               w_accept, w_cnt_zero, w_load, w_dec;
   logic               w_write, w_io, w_m1, w_act, w_late;
   logic [WAIT_CW-1:0] w_load_val;

   assign req_ready = ((r_state == ST_IDLE) || (r_state == ST_T3)) && busrq_n;
   assign w_accept  = req_valid && req_ready;

   // Strobes are decoded from the next state, so on an accepting edge the
   // incoming request's attributes must be used rather than the stale capture.
   assign w_write = w_accept ? req_write : r_write;
   assign w_io    = w_accept ? req_io    : r_io;
   assign w_m1    = w_accept ? req_m1    : r_m1;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!busrq_n)       w_next = ST_HOLD;
            else if (req_valid) w_next = ST_T1;
         end
         ST_T1:        w_next = ST_T2;
         ST_T2, ST_TW: w_next = (w_cnt_zero && wait_n) ? ST_T3 : ST_TW;
         ST_T3: begin
            if (w_accept)     w_next = ST_T1;
            else if (!busrq_n) w_next = ST_HOLD;
            else               w_next = ST_IDLE;
         end
         ST_HOLD: if (busrq_n) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_stb  = STROBE_IDLE;
      w_act  = (w_next == ST_T1) || (w_next == ST_T2) || (w_next == ST_TW) || (w_next == ST_T3);
      w_late = (w_next == ST_T2) || (w_next == ST_TW) || (w_next == ST_T3);
      if (!w_io) begin
         w_stb.mreq_n = !w_act;
         w_stb.m1_n   = !(w_act && w_m1);
         w_stb.rd_n   = !(w_act && !w_write);
         w_stb.wr_n   = !(w_write && (W_EARLY_WR ? w_late
                                      : ((w_next == ST_TW) || (w_next == ST_T3))));
      end else begin
         w_stb.iorq_n = !w_late;
         w_stb.rd_n   = !(w_late && !w_write);
         w_stb.wr_n   = !(w_late && w_write);
      end
   end

   assign w_load     = (r_state == ST_T1);
   assign w_load_val = r_io ? WAIT_CW'(IO_WAIT) : WAIT_CW'(MEM_WAIT);
   assign w_dec      = ((r_state == ST_T2) || (r_state == ST_TW)) && (w_next == ST_TW);

   tv80_wait_cnt u_wait_cnt (
      .i_clk      (clk),
      .i_rst_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_write   <= 1'b0;
         r_io      <= 1'b0;
         r_m1      <= 1'b0;
         r_rdata   <= '0;
         r_stb     <= STROBE_IDLE;
         r_busak_n <= 1'b1;
         r_bus_oe  <= 1'b1;
      end else begin
         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_write <= req_write;
            r_io    <= req_io;
            r_m1    <= req_m1;
         end
         if (((r_state == ST_T2) || (r_state == ST_TW)) && (w_next == ST_T3) && !r_write)
            r_rdata <= di;
         r_stb     <= w_stb;
         r_busak_n <= (w_next != ST_HOLD);
         r_bus_oe  <= (w_next != ST_HOLD);
      end
   end

   assign rsp_valid = (r_state == ST_T3);
   assign rsp_rdata = r_rdata;
   assign A         = r_addr;
   assign dout      = r_wdata;
   assign busak_n   = r_busak_n;
   assign bus_oe    = r_bus_oe;
   assign m1_n      = r_stb.m1_n;
   assign mreq_n    = r_stb.mreq_n;
   assign iorq_n    = r_stb.iorq_n;
   assign rd_n      = r_stb.rd_n;
   assign wr_n      = r_stb.wr_n;

endmodule

// File: tb/tb_tv80_bus_seq.sv
// Directed bench for tv80_bus_seq: dut_a (T2_WRITE=0) and dut_b (T2_WRITE=1)
// share all inputs; strobes are checked as {m1_n,mreq_n,iorq_n,rd_n,wr_n}.
module tb_tv80_bus_seq;

   localparam int AW = 16;
   localparam int DW = 8;

   localparam logic [4:0] S_IDLE = 5'b11111;
   localparam logic [4:0] S_MRD  = 5'b10101;
   localparam logic [4:0] S_M1RD = 5'b00101;
   localparam logic [4:0] S_MREQ = 5'b10111;
   localparam logic [4:0] S_MWR  = 5'b10110;
   localparam logic [4:0] S_IOWR = 5'b11010;
   localparam logic [4:0] S_IORD = 5'b11001;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid, req_write, req_io, req_m1;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata, di;
   logic          wait_n, busrq_n;

   logic          req_ready_a, rsp_valid_a, busak_n_a, bus_oe_a;
   logic          m1_n_a, mreq_n_a, iorq_n_a, rd_n_a, wr_n_a;
   logic [DW-1:0] rsp_rdata_a, dout_a;
   logic [AW-1:0] a_a;
   logic          req_ready_b, rsp_valid_b, busak_n_b, bus_oe_b;
   logic          m1_n_b, mreq_n_b, iorq_n_b, rd_n_b, wr_n_b;
   logic [DW-1:0] rsp_rdata_b, dout_b;
   logic [AW-1:0] a_b;
   logic [4:0]    stb_a, stb_b;

   logic [DW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   assign stb_a = {m1_n_a, mreq_n_a, iorq_n_a, rd_n_a, wr_n_a};
   assign stb_b = {m1_n_b, mreq_n_b, iorq_n_b, rd_n_b, wr_n_b};

   always #5 clk = ~clk;

   tv80_bus_seq #(.AW(AW), .DW(DW), .MEM_WAIT(0), .IO_WAIT(1), .T2_WRITE(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_a),
      .req_write(req_write), .req_io(req_io), .req_m1(req_m1), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
      .wait_n(wait_n), .busrq_n(busrq_n), .busak_n(busak_n_a), .bus_oe(bus_oe_a),
      .di(di), .A(a_a), .dout(dout_a), .m1_n(m1_n_a), .mreq_n(mreq_n_a),
      .iorq_n(iorq_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a)
   );

   tv80_bus_seq #(.AW(AW), .DW(DW), .MEM_WAIT(0), .IO_WAIT(1), .T2_WRITE(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_b),
      .req_write(req_write), .req_io(req_io), .req_m1(req_m1), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
      .wait_n(wait_n), .busrq_n(busrq_n), .busak_n(busak_n_b), .bus_oe(bus_oe_b),
      .di(di), .A(a_b), .dout(dout_b), .m1_n(m1_n_b), .mreq_n(mreq_n_b),
      .iorq_n(iorq_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [4:0] exp_stb, input logic exp_rsp);
      check_eq({tag, "_stb"}, {27'd0, stb_a}, {27'd0, exp_stb});
      check_eq({tag, "_rsp"}, {31'd0, rsp_valid_a}, {31'd0, exp_rsp});
   endtask

   task automatic put_req(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic write, input logic io, input logic m1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_wdata = wdata;
      req_write = write;
      req_io    = io;
      req_m1    = m1;
   endtask

   initial begin
      logic [AW-1:0] m1_addr [3];
      logic [DW-1:0] m1_data [3];
      m1_addr = '{16'h0100, 16'h0101, 16'h0102};
      m1_data = '{8'h11, 8'h22, 8'h33};

      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0; req_m1 = 1'b0;
      req_addr = '0; req_wdata = '0; di = '0; wait_n = 1'b1; busrq_n = 1'b1;
      step();
      step();
      chk_a("rst", S_IDLE, 1'b0);
      check_eq("rst_busak", {31'd0, busak_n_a}, 32'd1);
      check_eq("rst_oe", {31'd0, bus_oe_a}, 32'd1);
      check_eq("rst_addr", {16'd0, a_a}, 32'd0);
      check_eq("rst_rdata", {24'd0, rsp_rdata_a}, 32'd0);
      reset_n = 1'b1;
      step();

      // memory read, zero waits
      check_eq("mrd_ready", {31'd0, req_ready_a}, 32'd1);
      put_req(16'h1234, 8'h00, 1'b0, 1'b0, 1'b0);
      di = 8'hA5;
      step(); req_valid = 1'b0;
      chk_a("mrd_t1", S_MRD, 1'b0);
      check_eq("mrd_addr", {16'd0, a_a}, 32'h1234);
      check_eq("mrd_busy", {31'd0, req_ready_a}, 32'd0);
      step(); chk_a("mrd_t2", S_MRD, 1'b0);
      step(); chk_a("mrd_t3", S_MRD, 1'b1);
      check_eq("mrd_data", {24'd0, rsp_rdata_a}, 32'hA5);
      di = 8'h00;
      step(); chk_a("mrd_idle", S_IDLE, 1'b0);
      check_eq("mrd_hold_data", {24'd0, rsp_rdata_a}, 32'hA5);
      check_eq("mrd_hold_addr", {16'd0, a_a}, 32'h1234);

      // I/O write, one forced wait
      put_req(16'h0010, 8'h3C, 1'b1, 1'b1, 1'b0);
      step(); req_valid = 1'b0;
      chk_a("iowr_t1", S_IDLE, 1'b0);
      check_eq("iowr_dout", {24'd0, dout_a}, 32'h3C);
      step(); chk_a("iowr_t2", S_IOWR, 1'b0);
      check_eq("iowr_t2_b", {27'd0, stb_b}, {27'd0, S_IOWR});
      step(); chk_a("iowr_tw", S_IOWR, 1'b0);
      step(); chk_a("iowr_t3", S_IOWR, 1'b1);
      check_eq("iowr_t3_dout", {24'd0, dout_a}, 32'h3C);
      step(); chk_a("iowr_idle", S_IDLE, 1'b0);

      // memory write, external wait for 2 cycles; compare late vs early wr_n
      put_req(16'h4000, 8'h5A, 1'b1, 1'b0, 1'b0);
      wait_n = 1'b0;
      step(); req_valid = 1'b0;
      chk_a("mwr_t1", S_MREQ, 1'b0);
      check_eq("mwr_t1_b", {27'd0, stb_b}, {27'd0, S_MREQ});
      step(); chk_a("mwr_t2", S_MREQ, 1'b0);
      check_eq("mwr_t2_b", {27'd0, stb_b}, {27'd0, S_MWR});
      step(); chk_a("mwr_tw1", S_MWR, 1'b0);
      check_eq("mwr_tw1_b", {27'd0, stb_b}, {27'd0, S_MWR});
      step(); chk_a("mwr_tw2", S_MWR, 1'b0);
      wait_n = 1'b1;
      step(); chk_a("mwr_t3", S_MWR, 1'b1);
      check_eq("mwr_t3_b", {31'd0, rsp_valid_b}, 32'd1);
      check_eq("mwr_rdata_kept", {24'd0, rsp_rdata_a}, 32'hA5);
      step(); chk_a("mwr_idle", S_IDLE, 1'b0);

      // bus request wins over a simultaneous core request
      busrq_n = 1'b0;
      put_req(16'h2000, 8'h00, 1'b0, 1'b0, 1'b0);
      #1 check_eq("hold_not_ready", {31'd0, req_ready_a}, 32'd0);
      step(); chk_a("hold1", S_IDLE, 1'b0);
      check_eq("hold_busak", {31'd0, busak_n_a}, 32'd0);
      check_eq("hold_oe", {31'd0, bus_oe_a}, 32'd0);
      step(); check_eq("hold2_busak", {31'd0, busak_n_a}, 32'd0);
      check_eq("hold2_ready", {31'd0, req_ready_a}, 32'd0);
      busrq_n = 1'b1;
      step(); check_eq("unhold_busak", {31'd0, busak_n_a}, 32'd1);
      check_eq("unhold_oe", {31'd0, bus_oe_a}, 32'd1);
      check_eq("unhold_ready", {31'd0, req_ready_a}, 32'd1);
      chk_a("unhold_idle", S_IDLE, 1'b0);
      step(); req_valid = 1'b0;
      chk_a("unhold_t1", S_MRD, 1'b0);
      check_eq("unhold_addr", {16'd0, a_a}, 32'h2000);
      di = 8'h77;
      step(); chk_a("unhold_t2", S_MRD, 1'b0);
      step(); chk_a("unhold_t3", S_MRD, 1'b1);
      check_eq("unhold_data", {24'd0, rsp_rdata_a}, 32'h77);
      step(); chk_a("unhold_end", S_IDLE, 1'b0);

      // asynchronous reset while stretched in TW
      put_req(16'h0080, 8'h00, 1'b0, 1'b1, 1'b0);
      wait_n = 1'b0;
      step(); req_valid = 1'b0;
      chk_a("rstio_t1", S_IDLE, 1'b0);
      step(); chk_a("rstio_t2", S_IORD, 1'b0);
      step(); chk_a("rstio_tw", S_IORD, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk_a("rstio_async", S_IDLE, 1'b0);
      check_eq("rstio_addr", {16'd0, a_a}, 32'd0);
      check_eq("rstio_rdata", {24'd0, rsp_rdata_a}, 32'd0);
      #2 reset_n = 1'b1;
      wait_n = 1'b1;
      step(); chk_a("rstio_after", S_IDLE, 1'b0);
      check_eq("rstio_ready", {31'd0, req_ready_a}, 32'd1);
      step(); chk_a("rstio_after2", S_IDLE, 1'b0);

      // three back-to-back opcode fetches
      put_req(m1_addr[0], 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_a($sformatf("m1_%0d_t1", i), S_M1RD, 1'b0);
         check_eq($sformatf("m1_%0d_addr", i), {16'd0, a_a}, {16'd0, m1_addr[i]});
         step();
         chk_a($sformatf("m1_%0d_t2", i), S_M1RD, 1'b0);
         di = m1_data[i];
         exp_q.push_back(m1_data[i]);
         step();
         chk_a($sformatf("m1_%0d_t3", i), S_M1RD, 1'b1);
         check_eq($sformatf("m1_%0d_data", i), {24'd0, rsp_rdata_a}, {24'd0, exp_q.pop_front()});
         if (i < 2) req_addr = m1_addr[i+1];
         else       req_valid = 1'b0;
      end
      step(); chk_a("m1_idle", S_IDLE, 1'b0);
      check_eq("m1_queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tv80_bus_seq.md
TV80_BUS_SEQ -- requirements
Module: tv80_bus_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- AW, 16, address width
- DW, 8, data width
- MEM_WAIT, 0, forced wait states for memory cycles (0-7)
- IO_WAIT, 1, forced wait states for I/O cycles (0-7)
- T2_WRITE, 1, 1 = wr_n asserted from T2; 0 = wr_n asserted from the first state after T2
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- reset_n, in, 1, asynchronous active-low reset
- req_valid, in, 1, core requests a bus cycle
- req_ready, out, 1, sequencer accepts the request
- req_write, in, 1, 1 = write, 0 = read
- req_io, in, 1, 1 = I/O space, 0 = memory space
- req_m1, in, 1, opcode fetch
- req_addr, in, AW, cycle address
- req_wdata, in, DW, write data
- rsp_valid, out, 1, one-cycle pulse when the cycle completes
- rsp_rdata, out, DW, captured read data
- wait_n, in, 1, external wait, active low
- busrq_n, in, 1, external bus request
- busak_n, out, 1, bus acknowledge
- bus_oe, out, 1, A/dout/strobe drive enable
- di, in, DW, bus read data
- A, out, AW, bus address
- dout, out, DW, bus write data
- m1_n, mreq_n, iorq_n, rd_n, wr_n, out, 1 each, registered active-low strobes

Function
REQ-003 States: IDLE, T1, T2, TW, T3, HOLD; encoding lives in the package.
REQ-004 req_ready SHALL be 1 in IDLE and T3 when busrq_n=1; otherwise 0.
REQ-005 On an edge where req_valid&req_ready: capture addr/wdata/write/io/m1; next state T1.
REQ-006 T1→T2 unconditionally; on entering T2, load the wait counter with IO_WAIT if io, else MEM_WAIT.
REQ-007 From T2/TW: go to T3 when counter==0 and wait_n==1; otherwise go to TW, decrementing the counter if nonzero (saturates at 0).
REQ-008 T3→T1 if a new request is accepted; T3→HOLD if busrq_n==0; otherwise T3→IDLE.
REQ-009 IDLE→HOLD when busrq_n==0; busrq_n has priority over a simultaneous req_valid.
REQ-010 HOLD: busak_n=0, bus_oe=0, all strobes 1; leave to IDLE when busrq_n==1.
REQ-011 A and dout SHALL hold the captured values from T1 through T3; both hold their last value in IDLE.
REQ-012 Memory read: mreq_n=0 and rd_n=0 in T1..T3; m1_n=0 in T1..T3 when m1.
REQ-013 Memory write: mreq_n=0 in T1..T3; wr_n=0 in T2..T3 if T2_WRITE=1, else in TW..T3 and in T3.
REQ-014 I/O cycle: iorq_n=0 and rd_n/wr_n=0 in T2..T3; mreq_n stays 1; T2_WRITE does not apply.
REQ-015 All strobes SHALL be flops driven from next-state decode, so they change only on clock edges.
REQ-016 rdata SHALL capture di on the edge leaving T2/TW into T3 (read cycles only); rsp_valid=1 for exactly the T3 cycle; rsp_rdata holds until the next read capture.
REQ-017 Zero-wait latency: acceptance edge k, then T1, T2 and T3 at k+1, k+2 and k+3; back-to-back cycles give one cycle per 3 clocks.

Reset
REQ-018 While reset_n=0 (asynchronous): state=IDLE; all strobes=1; busak_n=1; bus_oe=1; rsp_valid=0; A, dout and rsp_rdata=0; counter=0.
REQ-019 Reset mid-cycle SHALL abort the cycle with no rsp_valid; after release the sequencer SHALL start in IDLE.

Structure
REQ-020 Package tv80_bus_pkg SHALL hold the state enum, the strobe bundle struct and the default wait constants.
REQ-021 The wait counter SHALL be a sub-module tv80_wait_cnt (load, decrement, zero flag), 3 bits wide.

Verification
REQ-022 Memory read at 0x1234, MEM_WAIT=0, wait_n=1, di=0xA5 -> mreq_n/rd_n low for 3 cycles; rsp_valid at k+3; rsp_rdata=0xA5.
REQ-023 I/O write at 0x0010, data 0x3C, IO_WAIT=1 -> sequence T1,T2,TW,T3; iorq_n/wr_n low for 3 cycles; dout=0x3C; mreq_n stays 1.
REQ-024 Memory write with T2_WRITE=0 and wait_n held low 2 cycles -> 2 TW states; wr_n low only from the first TW through T3.
REQ-025 busrq_n=0 and req_valid=1 together in IDLE -> HOLD, busak_n=0, bus_oe=0, request not accepted; busrq_n=1 -> IDLE, then the request is accepted.
REQ-026 reset_n pulsed low during TW -> strobes go high immediately with no clock; no rsp_valid; next cycle after release starts from IDLE.
REQ-027 Three back-to-back m1 reads -> rsp_valid every 3rd clock; m1_n low during each T1..T3.
